// File: rtl/yazmac_pkg.sv
// Shared types and default sizing for the yazmac_obegi register file.
// State encoding for the clear/ready sequencer.
package yazmac_pkg;

    localparam int VERI_W_VARSAYILAN  = 8;
    localparam int ADRES_W_VARSAYILAN = 3;

    typedef enum logic {
        TEMIZLE,
        HAZIR
    } durum_t;

endpackage

// File: rtl/yazmac_obegi_rezervasyon_tablosu.sv
// Pending-write bit per entry; a set beats a clear on the same entry. Both read taps are combinational and show the next-state bits.
// Registers update one cycle after the request. There is no backpressure: every request is taken in the cycle it arrives.
module rezervasyon_tablosu import yazmac_pkg::*; #(
    parameter int ADRES_W = ADRES_W_VARSAYILAN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_i,
    input  logic [ADRES_W-1:0] set_adres_i,
    input  logic               sil_i,
    input  logic [ADRES_W-1:0] sil_adres_i,
    input  logic [ADRES_W-1:0] oku1_adres_i,
    input  logic [ADRES_W-1:0] oku2_adres_i,
    output logic               mesgul1_o,
    output logic               mesgul2_o
);

    localparam int DERINLIK = 2**ADRES_W;

    logic [DERINLIK-1:0] bekleyen_q, bekleyen_d;

    // The clear is applied first, so a reservation in the same cycle wins.
    always_comb begin
        bekleyen_d = bekleyen_q;
        if (sil_i) bekleyen_d[sil_adres_i] = 1'b0;
        if (set_i) bekleyen_d[set_adres_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) bekleyen_q <= '0;
        else     bekleyen_q <= bekleyen_d;
    end

    assign mesgul1_o = bekleyen_d[oku1_adres_i];
    assign mesgul2_o = bekleyen_d[oku2_adres_i];

endmodule

// File: rtl/yazmac_obegi.sv
// Register file with 2 registered read ports, 1 write port, a write-first bypass and a pending-write scoreboard. A clear sequence runs after reset.
// Read latency is 1 cycle. There is no backpressure once hazir_o is high; writes and reservations are ignored while it is low.
module yazmac_obegi import yazmac_pkg::*; #(
    parameter int VERI_W  = VERI_W_VARSAYILAN,
    parameter int ADRES_W = ADRES_W_VARSAYILAN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADRES_W-1:0] oku1_adres,
    input  logic [ADRES_W-1:0] oku2_adres,
    output logic [VERI_W-1:0]  veri1_o,
    output logic [VERI_W-1:0]  veri2_o,
    output logic               mesgul1_o,
    output logic               mesgul2_o,
    input  logic [ADRES_W-1:0] yaz_adres,
    input  logic [VERI_W-1:0]  gelen_veri,
    input  logic               veriyi_yaz,
    input  logic               rezerve_et,
    input  logic [ADRES_W-1:0] rezerve_adres,
    output logic               hazir_o
);

    localparam int DERINLIK = 2**ADRES_W;
    localparam int SAYAC_W  = ADRES_W + 1;
    localparam logic [SAYAC_W-1:0] SON_ADRES = SAYAC_W'(DERINLIK - 1);
    localparam logic [SAYAC_W-1:0] BIR       = SAYAC_W'(1);

    durum_t              durum_q, durum_d;
    logic [SAYAC_W-1:0]  sayac_q, sayac_d;
    logic [VERI_W-1:0]   bellek_q [DERINLIK];
    logic [VERI_W-1:0]   veri1_q, veri1_d, veri2_q, veri2_d;
    logic                mesgul1_q, mesgul1_d, mesgul2_q, mesgul2_d;
    logic                bel_yaz;
    logic [ADRES_W-1:0]  bel_adres;
    logic [VERI_W-1:0]   bel_veri;
    logic                rez_set, rez_sil;
    logic                tap1, tap2;

    rezervasyon_tablosu #(.ADRES_W(ADRES_W)) u_rez (
        .clk          (clk),
        .rst          (rst),
        .set_i        (rez_set),
        .set_adres_i  (rezerve_adres),
        .sil_i        (rez_sil),
        .sil_adres_i  (yaz_adres),
        .oku1_adres_i (oku1_adres),
        .oku2_adres_i (oku2_adres),
        .mesgul1_o    (tap1),
        .mesgul2_o    (tap2)
    );

    always_comb begin
        durum_d   = durum_q;
        sayac_d   = sayac_q;
        bel_yaz   = 1'b0;
        bel_adres = yaz_adres;
        bel_veri  = gelen_veri;
        rez_set   = 1'b0;
        rez_sil   = 1'b0;
        veri1_d   = '0;
        veri2_d   = '0;
        mesgul1_d = 1'b0;
        mesgul2_d = 1'b0;
        case (durum_q)
            TEMIZLE: begin
                bel_yaz   = 1'b1;
                bel_adres = sayac_q[ADRES_W-1:0];
                bel_veri  = '0;
                sayac_d   = sayac_q + BIR;
                if (sayac_q == SON_ADRES) durum_d = HAZIR;
            end
            HAZIR: begin
                bel_yaz   = veriyi_yaz;
                rez_sil   = veriyi_yaz;
                rez_set   = rezerve_et;
                // A same-address write bypasses the array so the read is write-first.
                veri1_d   = (veriyi_yaz && (yaz_adres == oku1_adres)) ? gelen_veri : bellek_q[oku1_adres];
                veri2_d   = (veriyi_yaz && (yaz_adres == oku2_adres)) ? gelen_veri : bellek_q[oku2_adres];
                mesgul1_d = tap1;
                mesgul2_d = tap2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q   <= TEMIZLE;
            sayac_q   <= '0;
            veri1_q   <= '0;
            veri2_q   <= '0;
            mesgul1_q <= 1'b0;
            mesgul2_q <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            sayac_q   <= sayac_d;
            veri1_q   <= veri1_d;
            veri2_q   <= veri2_d;
            mesgul1_q <= mesgul1_d;
            mesgul2_q <= mesgul2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bel_yaz) bellek_q[bel_adres] <= bel_veri;
    end

    assign veri1_o   = veri1_q;
    assign veri2_o   = veri2_q;
    assign mesgul1_o = mesgul1_q;
    assign mesgul2_o = mesgul2_q;
    assign hazir_o   = (durum_q == HAZIR);

endmodule

// File: tb/tb_yazmac_obegi.sv
// Directed and random traffic against a reference model of yazmac_obegi. Expected read results go into a queue when a step is driven and are popped after the edge.
module tb_yazmac_obegi;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] oku1_adres, oku2_adres, yaz_adres, rezerve_adres;
    logic [7:0] gelen_veri;
    logic       veriyi_yaz, rezerve_et;
    logic [7:0] veri1_o, veri2_o;
    logic       mesgul1_o, mesgul2_o, hazir_o;

    always #5 clk = ~clk;

    yazmac_obegi #(.VERI_W(8), .ADRES_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .oku1_adres    (oku1_adres),
        .oku2_adres    (oku2_adres),
        .veri1_o       (veri1_o),
        .veri2_o       (veri2_o),
        .mesgul1_o     (mesgul1_o),
        .mesgul2_o     (mesgul2_o),
        .yaz_adres     (yaz_adres),
        .gelen_veri    (gelen_veri),
        .veriyi_yaz    (veriyi_yaz),
        .rezerve_et    (rezerve_et),
        .rezerve_adres (rezerve_adres),
        .hazir_o       (hazir_o)
    );

    typedef struct packed {
        logic [7:0] v1;
        logic [7:0] v2;
        logic       m1;
        logic       m2;
        logic       h;
    } bek_t;

    bek_t       sb[$];
    logic [7:0] m_mem [8];
    bit         m_res [8];
    int         m_cnt  = 0;
    int         gecen  = 0;
    int         hatali = 0;
    int         toplam = 0;

    task automatic kontrol(input string tag, input logic [7:0] gozlem, input logic [7:0] beklenen);
        toplam++;
        assert (gozlem === beklenen) gecen++;
        else begin
            hatali++;
            $error("FAIL %s: observed %0d expected %0d", tag, gozlem, beklenen);
        end
    endtask

    task automatic adim(input string tag, input bit r, input bit w, input logic [2:0] wa,
                        input logic [7:0] wd, input bit rv, input logic [2:0] ra,
                        input logic [2:0] a1, input logic [2:0] a2);
        bek_t e;
        bek_t g;
        rst           = r;
        veriyi_yaz    = w;
        yaz_adres     = wa;
        gelen_veri    = wd;
        rezerve_et    = rv;
        rezerve_adres = ra;
        oku1_adres    = a1;
        oku2_adres    = a2;
        e = '0;
        if (r) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) m_res[i] = 1'b0;
        end else if (m_cnt < 8) begin
            m_mem[m_cnt] = 8'd0;
            m_cnt++;
            e.h = (m_cnt == 8);
        end else begin
            e.v1 = (w && wa == a1) ? wd : m_mem[a1];
            e.v2 = (w && wa == a2) ? wd : m_mem[a2];
            if (w) begin
                m_res[wa] = 1'b0;
                m_mem[wa] = wd;
            end
            if (rv) m_res[ra] = 1'b1;
            e.m1 = m_res[a1];
            e.m2 = m_res[a2];
            e.h  = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            toplam++;
            hatali++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            g = sb.pop_front();
            kontrol($sformatf("%s.veri1", tag),   veri1_o,            g.v1);
            kontrol($sformatf("%s.veri2", tag),   veri2_o,            g.v2);
            kontrol($sformatf("%s.mesgul1", tag), {7'd0, mesgul1_o},  {7'd0, g.m1});
            kontrol($sformatf("%s.mesgul2", tag), {7'd0, mesgul2_o},  {7'd0, g.m2});
            kontrol($sformatf("%s.hazir", tag),   {7'd0, hazir_o},    {7'd0, g.h});
        end
    endtask

    task automatic bos(input string tag, input logic [2:0] a1, input logic [2:0] a2);
        adim(tag, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, a1, a2);
    endtask

    initial begin
        // Reset state, then the first clear, with writes and reservations that must be dropped.
        adim("reset", 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++)
            adim("clear1", 1'b0, 1'b1, 3'(i), 8'hF0, 1'b1, 3'(i), 3'(i), 3'(7 - i));

        // Fill every entry so a later clear has something to erase.
        for (int i = 0; i < 8; i++)
            adim("fill", 1'b0, 1'b1, 3'(i), 8'(8'hA0 + i), 1'b0, 3'd0, 3'(i), 3'd0);

        // Reset, 4 clear cycles, then reset again mid-clear.
        adim("reset2", 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++)
            adim("clearA", 1'b0, 1'b1, 3'(7 - i), 8'h5A, 1'b0, 3'd0, 3'd7, 3'd6);
        adim("reset3", 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++)
            adim("clearB", 1'b0, 1'b1, 3'(7 - i), 8'h77, 1'b1, 3'(i), 3'd4, 3'd5);
        for (int i = 0; i < 8; i++)
            bos("readzero", 3'(i), 3'(7 - i));

        // Write then read.
        adim("wr43", 1'b0, 1'b1, 3'd3, 8'd43, 1'b0, 3'd0, 3'd0, 3'd1);
        bos("rd43", 3'd3, 3'd2);

        // Same-cycle bypass on both ports.
        adim("byp26", 1'b0, 1'b1, 3'd6, 8'd26, 1'b0, 3'd0, 3'd6, 3'd6);

        // Scoreboard: reserve with a read, then the write clears it.
        adim("wr55", 1'b0, 1'b1, 3'd5, 8'h55, 1'b0, 3'd0, 3'd0, 3'd0);
        adim("rsv5", 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 3'd5, 3'd3);
        bos("rd5busy", 3'd5, 3'd5);
        adim("wr4", 1'b0, 1'b1, 3'd5, 8'd4, 1'b0, 3'd0, 3'd5, 3'd6);

        // Reserve and write to the same entry: data lands, reservation stays.
        adim("rsvwr2", 1'b0, 1'b1, 3'd2, 8'd7, 1'b1, 3'd2, 3'd2, 3'd0);
        bos("rd2", 3'd0, 3'd2);

        // Mixed random traffic.
        for (int i = 0; i < 40; i++)
            adim("rand", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

        // Reset from the ready state re-runs the whole clear.
        adim("reset4", 1'b1, 1'b1, 3'd1, 8'd9, 1'b1, 3'd1, 3'd1, 3'd1);
        for (int i = 0; i < 8; i++)
            bos("clearC", 3'(i), 3'd1);
        for (int i = 0; i < 8; i++)
            bos("readzero2", 3'(i), 3'(i));

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule

// File: doc/yazmac_obegi.md
# yazmac_obegi

Parametrised register file for the processor datapath; the next generation of the fixed 8×8 two-read/one-write store. It provides two registered read ports with write-first bypass and a per-entry reservation (pending-write) scoreboard for hazard detection. After reset it runs a hardware clear sequence instead of relying on initial values. It sits between instruction decode (addresses, reservations) and the ALU writeback path.

## Interface
- VERI_W, 8, data width of each entry
- ADRES_W, 3, address width; depth = 2**ADRES_W
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- oku1_adres  in  ADRES_W  read port 1 address
- oku2_adres  in  ADRES_W  read port 2 address
- veri1_o  out  VERI_W  read port 1 data, registered
- veri2_o  out  VERI_W  read port 2 data, registered
- mesgul1_o  out  1  entry at port 1 address is reserved (registered with veri1_o)
- mesgul2_o  out  1  same for port 2
- yaz_adres  in  ADRES_W  write address
- gelen_veri  in  VERI_W  write data
- veriyi_yaz  in  1  write enable
- rezerve_et  in  1  mark entry as awaiting a write
- rezerve_adres  in  ADRES_W  entry to reserve
- hazir_o  out  1  block is out of clear sequence and accepting traffic

## Operation
- States: TEMIZLE, HAZIR. rst forces TEMIZLE, clear counter to 0, and all reservation bits to 0.
- TEMIZLE: one entry written to 0 per cycle at index = counter; counter increments. After writing index depth-1, go to HAZIR. veriyi_yaz and rezerve_et are ignored; veri*_o and mesgul*_o are held at 0.
- HAZIR: stays until rst.
- Write: in HAZIR with veriyi_yaz=1, entry[yaz_adres] <= gelen_veri and its reservation bit clears.
- Reserve: in HAZIR with rezerve_et=1, reservation bit[rezerve_adres] sets.
- Reserve and write to the same address in one cycle: reservation wins (bit ends 1); data is still written.
- Read: each port registers entry[oku_adres] every HAZIR cycle. If veriyi_yaz targets the same address that cycle, the port returns gelen_veri (write-first bypass). Both ports may read the same address.
- mesgulN_o equals the next-state reservation bit of the read address, after that cycle's write/reserve updates. It is consistent with the bypassed data.
- Widths: no arithmetic on data. The counter is ADRES_W+1 bits so depth-1 is detected without wrap.

## Timing
- Reset values: veri1_o=0, veri2_o=0, mesgul1_o=0, mesgul2_o=0, hazir_o=0.
- Clear takes exactly 2**ADRES_W cycles after rst deasserts. hazir_o rises on the cycle after the last clear write.
- rst asserted mid-clear restarts the count from 0. rst asserted in HAZIR re-runs the full clear.
- Read latency is 1 cycle: address presented at edge N gives data valid after edge N+1.
- Write is visible to a same-address read in the same cycle via bypass. Non-bypassed reads see it from the next cycle.
- Reservation set at edge N is reported by mesgul at edge N+1 for a read issued in cycle N.

## Structure
- Package yazmac_pkg holds the state enum (TEMIZLE, HAZIR) and the default VERI_W/ADRES_W constants.
- One sub-module, rezervasyon_tablosu: a 2**ADRES_W-bit pending vector with set/clear/priority logic and two lookahead read taps. Storage, bypass and the FSM stay in the top.

## Test plan
- Clear: rst for 1 cycle, then count cycles. Required: hazir_o=0 for exactly 8 cycles, then 1. Reading all 8 addresses returns 0; the old contents must be gone.
- Write then read: write 8'd43 to 3, then read 3 next cycle. Required: veri1_o=43 one cycle later.
- Bypass: in the same cycle, write 8'd26 to 6 and read 6 on both ports. Required: veri1_o=veri2_o=26 next cycle.
- Scoreboard: reserve 5, read 5, then write 8'd4 to 5 with a read of 5 that cycle. Required: mesgul1_o=1 and stale data on the first read; mesgul1_o=0 and data 4 on the second.
- Reserve and write to 2 in the same cycle: reserve 2 and write 8'd7 to 2. Required: a later read shows data 7 and mesgul=1.
- Reset mid-clear: assert rst at clear cycle 4. Required: a further full 8 cycles of clear; writes attempted during clear are discarded.
